// File: rtl/or_serial_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : or_serial_tx                                                  |
// | Purpose  : Ships the 16-bit output-register value as two 8N1 bytes,      |
// |            low byte first, with a one-entry pending buffer.              |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module or_serial_tx #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        send,
   input  logic [15:0] data,
   output logic        tx,
   output logic        busy,
   output logic        pending,
   output logic        overrun,
   output logic        frame_done
);

   localparam int                 c_cnt_w = $clog2(CLKS_PER_BIT);
   localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } state_t;

   state_t               r_state;
   logic [c_cnt_w-1:0]   r_cnt;
   logic [2:0]           r_bit;
   logic                 r_byte;
   logic [15:0]          r_shift;
   logic [15:0]          r_hold;
   logic                 r_pending;
   logic                 r_overrun;
   logic                 r_tx;
   logic                 r_busy;
   logic                 r_frame_done;

   state_t               w_state_nx;
   logic [c_cnt_w-1:0]   w_cnt_nx;
   logic [2:0]           w_bit_nx;
   logic                 w_byte_nx;
   logic [15:0]          w_shift_nx;
   logic [15:0]          w_hold_nx;
   logic                 w_pending_nx;
   logic                 w_overrun_nx;
   logic                 w_tx_nx;
   logic [7:0]           w_cur_byte;
   logic                 w_last;
   logic                 w_frame_end;

   assign w_last      = (r_cnt == c_last);
   assign w_frame_end = (r_state == ST_STOP) && r_byte && w_last;

   always_comb begin
      w_state_nx   = r_state;
      w_cnt_nx     = w_last ? '0 : r_cnt + 1'b1;
      w_bit_nx     = r_bit;
      w_byte_nx    = r_byte;
      w_shift_nx   = r_shift;
      w_hold_nx    = r_hold;
      w_pending_nx = r_pending;
      w_overrun_nx = r_overrun;

      case (r_state)
         ST_IDLE: begin
            w_cnt_nx = '0;
            if (send) begin
               w_state_nx = ST_START;
               w_shift_nx = data;
               w_byte_nx  = 1'b0;
               w_bit_nx   = 3'd0;
            end
         end
         ST_START: begin
            if (w_last) begin
               w_state_nx = ST_DATA;
               w_bit_nx   = 3'd0;
            end
         end
         ST_DATA: begin
            if (w_last) begin
               if (r_bit == 3'd7) begin
                  w_state_nx = ST_STOP;
               end else begin
                  w_bit_nx = r_bit + 3'd1;
               end
            end
         end
         ST_STOP: begin
            if (w_last) begin
               if (!r_byte) begin
                  w_state_nx = ST_START;
                  w_byte_nx  = 1'b1;
               end else if (r_pending) begin
                  w_state_nx   = ST_START;
                  w_shift_nx   = r_hold;
                  w_byte_nx    = 1'b0;
                  w_pending_nx = 1'b0;
               end else if (send) begin
                  w_state_nx = ST_START;
                  w_shift_nx = data;
                  w_byte_nx  = 1'b0;
               end else begin
                  w_state_nx = ST_IDLE;
                  w_byte_nx  = 1'b0;
               end
            end
         end
         default: w_state_nx = ST_IDLE;
      endcase

      // A send at frame end with an empty buffer already went straight to the shifter.
      if (send && (r_state != ST_IDLE) && !(w_frame_end && !r_pending)) begin
         w_hold_nx    = data;
         w_pending_nx = 1'b1;
         if (r_pending && !w_frame_end) begin
            w_overrun_nx = 1'b1;
         end
      end
   end

   assign w_cur_byte = w_byte_nx ? w_shift_nx[15:8] : w_shift_nx[7:0];

   always_comb begin
      w_tx_nx = 1'b1;
      case (w_state_nx)
         ST_START: w_tx_nx = 1'b0;
         ST_DATA:  w_tx_nx = w_cur_byte[w_bit_nx];
         default:  w_tx_nx = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_cnt        <= '0;
         r_bit        <= 3'd0;
         r_byte       <= 1'b0;
         r_shift      <= 16'h0000;
         r_hold       <= 16'h0000;
         r_pending    <= 1'b0;
         r_overrun    <= 1'b0;
         r_tx         <= 1'b1;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_state      <= w_state_nx;
         r_cnt        <= w_cnt_nx;
         r_bit        <= w_bit_nx;
         r_byte       <= w_byte_nx;
         r_shift      <= w_shift_nx;
         r_hold       <= w_hold_nx;
         r_pending    <= w_pending_nx;
         r_overrun    <= w_overrun_nx;
         r_tx         <= w_tx_nx;
         r_busy       <= (w_state_nx != ST_IDLE);
         r_frame_done <= (w_state_nx == ST_STOP) && w_byte_nx && (w_cnt_nx == c_last);
      end
   end

   assign tx         = r_tx;
   assign busy       = r_busy;
   assign pending    = r_pending;
   assign overrun    = r_overrun;
   assign frame_done = r_frame_done;

endmodule
`default_nettype wire
